// File: rtl/sram_req_arbiter_if.sv
// One SRAM-like req/addr_ok/data_ok port. The master issues requests, the
// slave accepts them and returns the response.
interface sram_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Shares a single memory port between the instruction and data requesters, one
// transaction in flight, data first with a starvation guard for fetch.
module sram_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_r;
  logic [7:0]        cnt_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic              force_s;
  logic              inst_grant_s;
  logic              data_grant_s;
  logic              inst_dok_s;
  logic              data_dok_s;
  logic              mem_req_s;

  assign force_s = (cnt_r >= 8'(STARVE_MAX));

  // Next-state, grant and response decode
  always_comb begin
    state_nxt_s  = state_r;
    inst_grant_s = 1'b0;
    data_grant_s = 1'b0;
    inst_dok_s   = 1'b0;
    data_dok_s   = 1'b0;
    mem_req_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // No grant while reset is held, so addr_ok stays low during reset.
        if (reset) begin
          state_nxt_s = ST_IDLE;
        end else if (data.req && !(force_s && inst.req)) begin
          data_grant_s = 1'b1;
          state_nxt_s  = ST_ADDR;
        end else if (inst.req) begin
          inst_grant_s = 1'b1;
          state_nxt_s  = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        mem_req_s = 1'b1;
        if (mem.addr_ok) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_RESP: begin
        if (mem.data_ok) begin
          data_dok_s  = owner_r;
          inst_dok_s  = ~owner_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, owner, latched request fields and starvation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      cnt_r   <= 8'd0;
      wr_r    <= 1'b0;
      size_r  <= 2'd0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (data_grant_s) begin
        owner_r <= 1'b1;
        wr_r    <= data.wr;
        size_r  <= data.size;
        addr_r  <= data.addr;
        wdata_r <= data.wdata;
        // Bounded by STARVE_MAX: a pending inst blocks data once the limit is hit.
        cnt_r   <= inst.req ? (cnt_r + 8'd1) : 8'd0;
      end else if (inst_grant_s) begin
        owner_r <= 1'b0;
        wr_r    <= inst.wr;
        size_r  <= inst.size;
        addr_r  <= inst.addr;
        wdata_r <= inst.wdata;
        cnt_r   <= 8'd0;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign inst.addr_ok = inst_grant_s;
  assign data.addr_ok = data_grant_s;
  assign inst.data_ok = inst_dok_s;
  assign data.data_ok = data_dok_s;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  assign mem.req   = mem_req_s;
  assign mem.wr    = wr_r;
  assign mem.size  = size_r;
  assign mem.addr  = addr_r;
  assign mem.wdata = wdata_r;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: inputs change on the falling edge and
// outputs are compared 1 time unit later, before the next rising edge.
module tb_sram_req_arbiter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
  sram_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_bus),
    .data  (data_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where inputs are changed.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet_mem();
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd2;
    inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd2;
    data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'h0;

    // Reset state
    step(); settle();
    chk_val("rst_mem_req", 64'(mem_bus.req), 64'd0);
    chk_val("rst_inst_aok", 64'(inst_bus.addr_ok), 64'd0);
    chk_val("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
    step(); reset = 1'b0;

    // 1) single instruction read
    step();
    inst_bus.req = 1'b1; inst_bus.wr = 1'b0; inst_bus.size = 2'd2; inst_bus.addr = 32'hBFC0_0000;
    settle();
    chk_val("t1_inst_aok", 64'(inst_bus.addr_ok), 64'd1);
    chk_val("t1_data_aok", 64'(data_bus.addr_ok), 64'd0);
    chk_val("t1_mem_req_T", 64'(mem_bus.req), 64'd0);
    step();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    settle();
    chk_val("t1_mem_req_T1", 64'(mem_bus.req), 64'd1);
    chk_val("t1_mem_addr", 64'(mem_bus.addr), 64'hBFC0_0000);
    chk_val("t1_mem_wr", 64'(mem_bus.wr), 64'd0);
    step();
    mem_bus.addr_ok = 1'b0;
    settle();
    chk_val("t1_mem_req_T2", 64'(mem_bus.req), 64'd0);
    chk_val("t1_inst_dok_T2", 64'(inst_bus.data_ok), 64'd0);
    step();
    mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h2401_0001;
    settle();
    chk_val("t1_inst_dok", 64'(inst_bus.data_ok), 64'd1);
    chk_val("t1_inst_rdata", 64'(inst_bus.rdata), 64'h2401_0001);
    chk_val("t1_data_dok", 64'(data_bus.data_ok), 64'd0);
    step();
    quiet_mem();
    settle();
    chk_val("t1_inst_dok_end", 64'(inst_bus.data_ok), 64'd0);
    chk_val("t1_mem_req_end", 64'(mem_bus.req), 64'd0);

    // 2) simultaneous inst read and data write: data first
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0004;
    data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd2;
    data_bus.addr = 32'h8000_1000; data_bus.wdata = 32'hDEAD_BEEF;
    settle();
    chk_val("t2_data_aok", 64'(data_bus.addr_ok), 64'd1);
    chk_val("t2_inst_aok", 64'(inst_bus.addr_ok), 64'd0);
    step();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    settle();
    chk_val("t2_mem_req", 64'(mem_bus.req), 64'd1);
    chk_val("t2_mem_wr", 64'(mem_bus.wr), 64'd1);
    chk_val("t2_mem_wdata", 64'(mem_bus.wdata), 64'hDEAD_BEEF);
    chk_val("t2_mem_addr", 64'(mem_bus.addr), 64'h8000_1000);
    chk_val("t2_inst_aok_addr", 64'(inst_bus.addr_ok), 64'd0);
    step();
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    settle();
    chk_val("t2_data_dok", 64'(data_bus.data_ok), 64'd1);
    chk_val("t2_inst_dok", 64'(inst_bus.data_ok), 64'd0);
    step();
    quiet_mem();
    settle();
    chk_val("t2_inst_aok_next", 64'(inst_bus.addr_ok), 64'd1);
    step();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    settle();
    chk_val("t2_inst_mem_addr", 64'(mem_bus.addr), 64'hBFC0_0004);
    chk_val("t2_inst_mem_wr", 64'(mem_bus.wr), 64'd0);
    step();
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    settle();
    chk_val("t2_inst_dok_done", 64'(inst_bus.data_ok), 64'd1);
    step();
    quiet_mem();

    // 3) starvation guard: D D D D I D D D D I with both held
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0008;
    data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.addr = 32'h8000_3000;
    for (int g = 0; g < 10; g++) begin
      logic exp_inst;
      exp_inst = (g == 4) || (g == 9);
      settle();
      chk_val($sformatf("t3_inst_aok_%0d", g), 64'(inst_bus.addr_ok), 64'(exp_inst));
      chk_val($sformatf("t3_data_aok_%0d", g), 64'(data_bus.addr_ok), 64'(!exp_inst));
      step();
      mem_bus.addr_ok = 1'b1;
      settle();
      chk_val($sformatf("t3_no_aok_%0d", g), 64'({inst_bus.addr_ok, data_bus.addr_ok}), 64'd0);
      chk_val($sformatf("t3_mem_addr_%0d", g), 64'(mem_bus.addr),
              exp_inst ? 64'hBFC0_0008 : 64'h8000_3000);
      step();
      mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
      settle();
      chk_val($sformatf("t3_dok_%0d", g), 64'({inst_bus.data_ok, data_bus.data_ok}),
              exp_inst ? 64'd2 : 64'd1);
      step();
      quiet_mem();
    end
    inst_bus.req = 1'b0; data_bus.req = 1'b0;
    step();

    // 4) memory stalls addr_ok for 5 cycles; a stray data_ok in ADDR is ignored
    data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.size = 2'd1; data_bus.addr = 32'h8000_2000;
    settle();
    chk_val("t4_data_aok", 64'(data_bus.addr_ok), 64'd1);
    step();
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_000C;
    data_bus.addr = 32'h8000_2F00; data_bus.size = 2'd2;
    for (int w = 0; w < 5; w++) begin
      mem_bus.data_ok = (w == 2);
      settle();
      chk_val($sformatf("t4_mem_req_%0d", w), 64'(mem_bus.req), 64'd1);
      chk_val($sformatf("t4_mem_addr_%0d", w), 64'(mem_bus.addr), 64'h8000_2000);
      chk_val($sformatf("t4_mem_size_%0d", w), 64'(mem_bus.size), 64'd1);
      chk_val($sformatf("t4_aok_%0d", w), 64'({inst_bus.addr_ok, data_bus.addr_ok}), 64'd0);
      chk_val($sformatf("t4_dok_%0d", w), 64'({inst_bus.data_ok, data_bus.data_ok}), 64'd0);
      step();
    end
    data_bus.req = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1;
    settle();
    chk_val("t4_mem_req_last", 64'(mem_bus.req), 64'd1);
    step();
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    settle();
    chk_val("t4_data_dok", 64'(data_bus.data_ok), 64'd1);
    step();
    quiet_mem();
    settle();
    chk_val("t4_inst_aok_after", 64'(inst_bus.addr_ok), 64'd1);
    step();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    step();
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1;
    settle();
    chk_val("t4_inst_dok", 64'(inst_bus.data_ok), 64'd1);
    step();
    quiet_mem();

    // 5) reset while in RESP; the late memory response is dropped
    inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0010;
    step();
    inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    step();
    mem_bus.addr_ok = 1'b0;
    reset = 1'b1; data_bus.req = 1'b1; data_bus.addr = 32'h8000_4000;
    mem_bus.rdata = 32'h5A5A_5A5A;
    settle();
    chk_val("t5_rst_mem_req", 64'(mem_bus.req), 64'd0);
    chk_val("t5_rst_mem_addr", 64'(mem_bus.addr), 64'd0);
    chk_val("t5_rst_mem_fields", 64'({mem_bus.wr, mem_bus.size, mem_bus.wdata}), 64'd0);
    chk_val("t5_rst_aok", 64'({inst_bus.addr_ok, data_bus.addr_ok}), 64'd0);
    chk_val("t5_rst_dok", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    chk_val("t5_rst_rdata", 64'(inst_bus.rdata), 64'h5A5A_5A5A);
    step();
    reset = 1'b0; data_bus.req = 1'b0;
    step();
    step();
    mem_bus.data_ok = 1'b1;
    settle();
    chk_val("t5_late_dok", 64'({inst_bus.data_ok, data_bus.data_ok}), 64'd0);
    chk_val("t5_late_mem_req", 64'(mem_bus.req), 64'd0);
    step();
    quiet_mem();

    // 6) data byte read after the reset
    data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.size = 2'd0; data_bus.addr = 32'h8000_0003;
    settle();
    chk_val("t6_data_aok", 64'(data_bus.addr_ok), 64'd1);
    step();
    data_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
    settle();
    chk_val("t6_mem_size", 64'(mem_bus.size), 64'd0);
    chk_val("t6_mem_addr", 64'(mem_bus.addr), 64'h8000_0003);
    step();
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0000_00A5;
    settle();
    chk_val("t6_data_dok", 64'(data_bus.data_ok), 64'd1);
    chk_val("t6_data_rdata", 64'(data_bus.rdata), 64'h0000_00A5);
    step();
    quiet_mem();
    settle();
    chk_val("t6_dok_pulse_end", 64'(data_bus.data_ok), 64'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
